// File: rtl/pcie_phy_pkg.sv
// Shared 8b/10b K-symbol codes, ordered-set types and receive FSM states
// for the Gen1/2 receive-side packet disassembly path.
package pcie_phy_pkg;

  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_FTS = 8'h3C;
  localparam logic [7:0] K_IDL = 8'h7C;
  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_PAD = 8'hF7;

  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] TS2_ID = 8'h45;

  typedef enum logic [2:0] {
    OS_SKP  = 3'd0,
    OS_TS1  = 3'd1,
    OS_TS2  = 3'd2,
    OS_EIOS = 3'd3,
    OS_FTS  = 3'd4
  } os_type_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_OS_ID = 3'd1,
    S_SKP   = 3'd2,
    S_EIOS  = 3'd3,
    S_FTS   = 3'd4,
    S_TS    = 3'd5,
    S_PKT   = 3'd6
  } rx_state_e;

  function automatic logic is_k_sym(input logic [7:0] sym, input logic k, input logic [7:0] code);
    return k && (sym == code);
  endfunction

endpackage

// File: rtl/pkt_disasm_os_detect.sv
// Ordered-set classifier (SKP/TS1/TS2/EIOS/FTS) with symbol counter and
// optional TS link/lane/N_FTS capture (PKT_DISASM_TS_DECODE_EN).
module pkt_disasm_os_detect
  import pcie_phy_pkg::*;
#(
  parameter int unsigned MIN_SKP = 1,
  parameter int unsigned MAX_SKP = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] sym_i,
  input  logic       sym_k_i,
  input  logic       sym_valid_i,
  input  logic       pkt_active_i,
  output logic       idle_dec_o,
  output logic       os_err_o,
  output logic       os_valid_o,
  output logic [2:0] os_type_o,
  output logic [7:0] ts_link_o,
  output logic [7:0] ts_lane_o,
  output logic [7:0] ts_nfts_o
);

  localparam logic [4:0] MIN_SKP_C = 5'(MIN_SKP);
  localparam logic [4:0] MAX_SKP_C = 5'(MAX_SKP);

  rx_state_e  state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       ts1_q, ts1_d, ts2_q, ts2_d;
  logic       valid_q, valid_d;
  os_type_e   type_q, type_d;
  logic       err, idle_dec;
  logic       is_com, is_skp, is_idl, is_fts, is_stp, is_sdp, is_pad;
  logic       m1, m2;
  logic [4:0] ts_idx;

  assign is_com = is_k_sym(sym_i, sym_k_i, K_COM);
  assign is_skp = is_k_sym(sym_i, sym_k_i, K_SKP);
  assign is_idl = is_k_sym(sym_i, sym_k_i, K_IDL);
  assign is_fts = is_k_sym(sym_i, sym_k_i, K_FTS);
  assign is_stp = is_k_sym(sym_i, sym_k_i, K_STP);
  assign is_sdp = is_k_sym(sym_i, sym_k_i, K_SDP);
  assign is_pad = is_k_sym(sym_i, sym_k_i, K_PAD);
  assign m1     = !sym_k_i && (sym_i == TS1_ID);
  assign m2     = !sym_k_i && (sym_i == TS2_ID);
  assign ts_idx = cnt_q + 5'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ts1_q   <= 1'b0;
      ts2_q   <= 1'b0;
      valid_q <= 1'b0;
      type_q  <= OS_SKP;
    end else if (sym_valid_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ts1_q   <= ts1_d;
      ts2_q   <= ts2_d;
      valid_q <= valid_d;
      type_q  <= type_d;
    end else begin
      valid_q <= 1'b0;
    end
  end

  // A SKP set has no fixed length: its terminating symbol is also decoded as if in idle.
  always_comb begin
    idle_dec = 1'b0;
    case (state_q)
      S_IDLE:  idle_dec = 1'b1;
      S_SKP:   idle_dec = !is_skp;
      default: idle_dec = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ts1_d   = ts1_q;
    ts2_d   = ts2_q;
    valid_d = 1'b0;
    type_d  = type_q;
    err     = 1'b0;
    case (state_q)
      S_OS_ID: begin
        cnt_d = 5'd1;
        if (is_skp)        state_d = S_SKP;
        else if (is_idl)   state_d = S_EIOS;
        else if (is_fts)   state_d = S_FTS;
        else if (!sym_k_i) state_d = S_TS;
        else if (is_com)   err = 1'b1;
        else begin
          err     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_SKP: begin
        if (is_skp) begin
          if (cnt_q <= MAX_SKP_C) cnt_d = cnt_q + 5'd1;
        end else if (cnt_q >= MIN_SKP_C && cnt_q <= MAX_SKP_C) begin
          valid_d = 1'b1;
          type_d  = OS_SKP;
        end else begin
          err = 1'b1;
        end
      end
      S_EIOS, S_FTS: begin
        if ((state_q == S_EIOS) ? is_idl : is_fts) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd2) begin
            valid_d = 1'b1;
            type_d  = (state_q == S_EIOS) ? OS_EIOS : OS_FTS;
            state_d = S_IDLE;
          end
        end else begin
          err     = 1'b1;
          state_d = is_com ? S_OS_ID : S_IDLE;
        end
      end
      S_TS: begin
        if (is_com) begin
          err     = 1'b1;
          state_d = S_OS_ID;
        end else begin
          cnt_d = ts_idx;
          if (ts_idx == 5'd6) begin
            ts1_d = m1;
            ts2_d = m2;
          end else if (ts_idx > 5'd6) begin
            ts1_d = ts1_q & m1;
            ts2_d = ts2_q & m2;
          end
          if (ts_idx == 5'd15) begin
            state_d = S_IDLE;
            if (ts1_d) begin
              valid_d = 1'b1;
              type_d  = OS_TS1;
            end else if (ts2_d) begin
              valid_d = 1'b1;
              type_d  = OS_TS2;
            end else begin
              err = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
    if (idle_dec) begin
      state_d = is_com ? S_OS_ID : S_IDLE;
      if (!is_com && !pkt_active_i && sym_k_i && !is_stp && !is_sdp && !is_pad) err = 1'b1;
    end
  end

  assign idle_dec_o = idle_dec;
  assign os_err_o   = err;
  assign os_valid_o = valid_q;
  assign os_type_o  = type_q;

`ifdef PKT_DISASM_TS_DECODE_EN
  logic [7:0] link_sh_q, lane_sh_q, nfts_sh_q;
  logic [7:0] link_q, lane_q, nfts_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      link_sh_q <= '0;
      lane_sh_q <= '0;
      nfts_sh_q <= '0;
      link_q    <= '0;
      lane_q    <= '0;
      nfts_q    <= '0;
    end else if (sym_valid_i) begin
      if (state_q == S_OS_ID && !sym_k_i)               link_sh_q <= sym_i;
      if (state_q == S_TS && !is_com && cnt_q == 5'd1) lane_sh_q <= sym_i;
      if (state_q == S_TS && !is_com && cnt_q == 5'd2) nfts_sh_q <= sym_i;
      if (valid_d && (type_d == OS_TS1 || type_d == OS_TS2)) begin
        link_q <= link_sh_q;
        lane_q <= lane_sh_q;
        nfts_q <= nfts_sh_q;
      end
    end
  end

  assign ts_link_o = link_q;
  assign ts_lane_o = lane_q;
  assign ts_nfts_o = nfts_q;
`else
  assign ts_link_o = '0;
  assign ts_lane_o = '0;
  assign ts_nfts_o = '0;
`endif

endmodule

// File: rtl/packet_disassembly.sv
// Receive packet framing: strips STP/SDP..END/EDB, one-byte hold for EOP tagging,
// length watchdog. TS field outputs are live only with PKT_DISASM_TS_DECODE_EN.
module packet_disassembly
  import pcie_phy_pkg::*;
#(
  parameter int unsigned MAX_PKT_BYTES = 4096,
  parameter int unsigned MIN_SKP       = 1,
  parameter int unsigned MAX_SKP       = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] sym_i,
  input  logic       sym_k_i,
  input  logic       sym_valid_i,
  output logic [7:0] pkt_data_o,
  output logic       pkt_valid_o,
  output logic       pkt_sop_o,
  output logic       pkt_eop_o,
  output logic       pkt_abort_o,
  output logic       pkt_type_o,
  output logic       os_valid_o,
  output logic [2:0] os_type_o,
  output logic [7:0] ts_link_o,
  output logic [7:0] ts_lane_o,
  output logic [7:0] ts_nfts_o,
  output logic       framing_err_o
);

  localparam int unsigned    WD_W   = $clog2(MAX_PKT_BYTES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_PKT_BYTES);

  rx_state_e       pstate_q, pstate_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_vld_q, hold_vld_d;
  logic            first_q, first_d;
  logic            type_q, type_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            pend_q, pend_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic            abort_q, abort_d, err_q, err_d;
  logic            emit, emit_eop, abort, perr, start;
  logic            os_idle_dec, os_err;
  logic            is_stp, is_sdp, is_end;

  assign is_stp = is_k_sym(sym_i, sym_k_i, K_STP);
  assign is_sdp = is_k_sym(sym_i, sym_k_i, K_SDP);
  assign is_end = is_k_sym(sym_i, sym_k_i, K_END);

  pkt_disasm_os_detect #(
    .MIN_SKP (MIN_SKP),
    .MAX_SKP (MAX_SKP)
  ) u_os_detect (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .sym_i        (sym_i),
    .sym_k_i      (sym_k_i),
    .sym_valid_i  (sym_valid_i),
    .pkt_active_i (pstate_q == S_PKT),
    .idle_dec_o   (os_idle_dec),
    .os_err_o     (os_err),
    .os_valid_o   (os_valid_o),
    .os_type_o    (os_type_o),
    .ts_link_o    (ts_link_o),
    .ts_lane_o    (ts_lane_o),
    .ts_nfts_o    (ts_nfts_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pstate_q   <= S_IDLE;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      first_q    <= 1'b0;
      type_q     <= 1'b0;
      wd_q       <= '0;
      pend_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      abort_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (sym_valid_i) begin
        pstate_q   <= pstate_d;
        hold_q     <= hold_d;
        hold_vld_q <= hold_vld_d;
        first_q    <= first_d;
        type_q     <= type_d;
        wd_q       <= wd_d;
      end
      pend_q  <= sym_valid_i & pend_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    pstate_d   = pstate_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    first_d    = first_q;
    type_d     = type_q;
    wd_d       = wd_q;
    emit       = 1'b0;
    emit_eop   = 1'b0;
    abort      = 1'b0;
    perr       = 1'b0;
    pend_d     = 1'b0;
    start      = 1'b0;
    case (pstate_q)
      S_IDLE: start = os_idle_dec && (is_stp || is_sdp);
      S_PKT: begin
        if (!sym_k_i) begin
          emit = hold_vld_q;
          // Overflow byte is dropped; the held byte still goes out, so the abort trails by a cycle.
          if (wd_q == WD_MAX) begin
            pend_d     = 1'b1;
            hold_vld_d = 1'b0;
            pstate_d   = S_IDLE;
          end else begin
            hold_d     = sym_i;
            hold_vld_d = 1'b1;
            wd_d       = wd_q + WD_W'(1);
          end
        end else if (is_end) begin
          emit       = hold_vld_q;
          emit_eop   = hold_vld_q;
          perr       = !hold_vld_q;
          hold_vld_d = 1'b0;
          pstate_d   = S_IDLE;
        end else begin
          abort      = hold_vld_q;
          perr       = 1'b1;
          hold_vld_d = 1'b0;
          pstate_d   = S_IDLE;
          start      = is_stp || is_sdp;
        end
      end
      default: pstate_d = S_IDLE;
    endcase
    if (start) begin
      pstate_d   = S_PKT;
      type_d     = is_sdp;
      first_d    = 1'b1;
      hold_vld_d = 1'b0;
      wd_d       = '0;
    end
    if (emit) first_d = 1'b0;
  end

  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    abort_d = pend_q;
    err_d   = pend_q;
    if (sym_valid_i) begin
      if (emit) data_d = hold_q;
      valid_d = emit;
      sop_d   = emit & first_q;
      eop_d   = emit_eop;
      abort_d = abort | pend_q;
      err_d   = perr | os_err | pend_q;
    end
  end

  assign pkt_data_o    = data_q;
  assign pkt_valid_o   = valid_q;
  assign pkt_sop_o     = sop_q;
  assign pkt_eop_o     = eop_q;
  assign pkt_abort_o   = abort_q;
  assign pkt_type_o    = type_q;
  assign framing_err_o = err_q;

endmodule

// File: tb/tb_packet_disassembly.sv
// Directed self-checking bench for packet_disassembly (optionally PKT_DISASM_TS_DECODE_EN).
module tb_packet_disassembly;
  import pcie_phy_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sym;
  logic       sym_k;
  logic       sym_valid;
  logic [7:0] pkt_data, ts_link, ts_lane, ts_nfts;
  logic       pkt_valid, pkt_sop, pkt_eop, pkt_abort, pkt_type, os_valid, framing_err;
  logic [2:0] os_type;

  packet_disassembly #(
    .MAX_PKT_BYTES (4096),
    .MIN_SKP       (1),
    .MAX_SKP       (5)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .sym_i         (sym),
    .sym_k_i       (sym_k),
    .sym_valid_i   (sym_valid),
    .pkt_data_o    (pkt_data),
    .pkt_valid_o   (pkt_valid),
    .pkt_sop_o     (pkt_sop),
    .pkt_eop_o     (pkt_eop),
    .pkt_abort_o   (pkt_abort),
    .pkt_type_o    (pkt_type),
    .os_valid_o    (os_valid),
    .os_type_o     (os_type),
    .ts_link_o     (ts_link),
    .ts_lane_o     (ts_lane),
    .ts_nfts_o     (ts_nfts),
    .framing_err_o (framing_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [10:0] bytes_q[$];
  logic [2:0]  os_q[$];
  int unsigned os_cyc_q[$];
  int          n_abort, n_err, n_clash;
  int unsigned last_cyc;

  always @(negedge clk) begin
    if (pkt_valid) bytes_q.push_back({pkt_type, pkt_eop, pkt_sop, pkt_data});
    if (os_valid) begin
      os_q.push_back(os_type);
      os_cyc_q.push_back(cyc);
    end
    if (pkt_abort) n_abort++;
    if (framing_err) n_err++;
    if (pkt_abort && pkt_valid) n_clash++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic t, input logic e, input logic s, input logic [7:0] d);
    return {t, e, s, d};
  endfunction

  function automatic logic [10:0] byte_at(input int i);
    return (i < bytes_q.size()) ? bytes_q[i] : 11'h7FF;
  endfunction

  function automatic logic [2:0] os_at(input int i);
    return (i < os_q.size()) ? os_q[i] : 3'h7;
  endfunction

  task automatic clr_log();
    bytes_q.delete();
    os_q.delete();
    os_cyc_q.delete();
    n_abort = 0;
    n_err   = 0;
  endtask

  task automatic send(input logic k, input logic [7:0] s, input int unsigned gap = 0);
    sym = s; sym_k = k; sym_valid = 1'b1;
    @(posedge clk); #1;
    last_cyc = cyc;
    if (gap > 0) begin
      sym = K_END; sym_k = 1'b1; sym_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int unsigned n);
    sym_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_ts(input logic [7:0] link, input logic [7:0] id, input logic [7:0] last);
    send(1, K_COM); send(0, link); send(0, 8'h02); send(0, 8'h20);
    send(0, 8'h00); send(0, 8'h00);
    for (int i = 0; i < 9; i++) send(0, id);
    send(0, last);
  endtask

  initial begin
    int bad;
    rst = 1'b1; sym = '0; sym_k = 1'b0; sym_valid = 1'b0;
    n_clash = 0;
    clr_log();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {pkt_data, pkt_valid, pkt_sop, pkt_eop, pkt_abort, pkt_type, os_valid,
                         framing_err, os_type}, '0);
    check("reset_ts", {ts_link, ts_lane, ts_nfts}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    clr_log();
    send(1, K_COM); send(1, K_SKP); send(1, K_SKP); send(1, K_SKP); send(0, 8'h00);
    idle(3);
    check("skp3_cnt", os_q.size(), 1);
    check("skp3_type", os_at(0), OS_SKP);
    check("skp3_time", os_cyc_q.size() > 0 ? os_cyc_q[0] : 0, last_cyc);
    check("skp3_err", n_err, 0);

    clr_log();
    send(1, K_COM); for (int i = 0; i < 5; i++) send(1, K_SKP); send(0, 8'h00);
    send(1, K_COM); for (int i = 0; i < 6; i++) send(1, K_SKP); send(0, 8'h00);
    idle(3);
    check("skp_max_cnt", os_q.size(), 1);
    check("skp_over_err", n_err, 1);

    clr_log();
    send_ts(8'h01, TS1_ID, TS1_ID);
    idle(3);
    check("ts1_cnt", os_q.size(), 1);
    check("ts1_type", os_at(0), OS_TS1);
    check("ts1_time", os_cyc_q.size() > 0 ? os_cyc_q[0] : 0, last_cyc);
`ifdef PKT_DISASM_TS_DECODE_EN
    check("ts1_fields", {ts_link, ts_lane, ts_nfts}, 24'h010220);
`else
    check("ts1_fields_tied", {ts_link, ts_lane, ts_nfts}, 24'h0);
`endif

    clr_log();
    send_ts(8'h07, TS2_ID, TS2_ID);
    send_ts(8'h09, TS1_ID, TS2_ID);
    idle(3);
    check("ts2_cnt", os_q.size(), 1);
    check("ts2_type", os_at(0), OS_TS2);
    check("ts_mixed_err", n_err, 1);
`ifdef PKT_DISASM_TS_DECODE_EN
    check("ts2_fields_held", {ts_link, ts_lane, ts_nfts}, 24'h070220);
`else
    check("ts2_fields_tied", {ts_link, ts_lane, ts_nfts}, 24'h0);
`endif

    clr_log();
    send(1, K_COM); send(1, K_IDL); send(1, K_IDL); send(1, K_IDL);
    send(1, K_COM); send(1, K_FTS); send(1, K_FTS); send(1, K_FTS);
    idle(3);
    check("eios_fts_cnt", os_q.size(), 2);
    check("eios_type", os_at(0), OS_EIOS);
    check("fts_type", os_at(1), OS_FTS);

    for (int g = 0; g < 2; g++) begin
      clr_log();
      send(1, K_STP, g * 2); send(0, 8'h11, g * 2); send(0, 8'h22, g * 2);
      send(0, 8'h33, g * 2); send(1, K_END, g * 2);
      idle(3);
      check("tlp_cnt", bytes_q.size(), 3);
      check("tlp_b0", byte_at(0), mk(0, 0, 1, 8'h11));
      check("tlp_b1", byte_at(1), mk(0, 0, 0, 8'h22));
      check("tlp_b2", byte_at(2), mk(0, 1, 0, 8'h33));
      check("tlp_abort_err", {n_abort[15:0], n_err[15:0]}, 0);
    end

    clr_log();
    send(1, K_SDP); send(0, 8'hAA); send(0, 8'hBB); send(1, K_EDB);
    idle(3);
    check("edb_cnt", bytes_q.size(), 1);
    check("edb_b0", byte_at(0), mk(1, 0, 1, 8'hAA));
    check("edb_abort", n_abort, 1);
    check("edb_err", n_err, 1);

    clr_log();
    send(1, K_STP); send(1, K_END);
    idle(3);
    check("empty_cnt", bytes_q.size(), 0);
    check("empty_abort_err", {n_abort[15:0], n_err[15:0]}, 32'h0000_0001);

    clr_log();
    send(1, K_STP); send(0, 8'h11); send(0, 8'h22); send(1, K_SDP); send(0, 8'h33); send(1, K_END);
    idle(3);
    check("restart_cnt", bytes_q.size(), 2);
    check("restart_b0", byte_at(0), mk(0, 0, 1, 8'h11));
    check("restart_b1", byte_at(1), mk(1, 1, 1, 8'h33));
    check("restart_abort_err", {n_abort[15:0], n_err[15:0]}, 32'h0001_0001);

    clr_log();
    send(1, K_COM); send(1, K_IDL); send(1, K_IDL); send(1, K_SKP);
    send(1, K_STP); send(0, 8'h05); send(1, K_END);
    idle(3);
    check("eios_bad_err", n_err, 1);
    check("eios_bad_os", os_q.size(), 0);
    check("recover_b0", byte_at(0), mk(0, 1, 1, 8'h05));

    clr_log();
    send(1, K_STP);
    for (int i = 0; i <= 4096; i++) send(0, i[7:0]);
    idle(3);
    check("wd_cnt", bytes_q.size(), 4096);
    bad = 0;
    for (int i = 0; i < 4096; i++)
      if (byte_at(i) !== mk(0, 0, (i == 0), i[7:0])) bad++;
    check("wd_data_seq", bad, 0);
    check("wd_abort_err", {n_abort[15:0], n_err[15:0]}, 32'h0001_0001);
    clr_log();
    send(0, 8'h99); send(1, K_STP); send(0, 8'h77); send(1, K_END);
    idle(3);
    check("wd_idle_after", bytes_q.size(), 1);
    check("wd_idle_b0", byte_at(0), mk(0, 1, 1, 8'h77));

    clr_log();
    send(1, K_STP); send(0, 8'h11); send(0, 8'h22);
    rst = 1'b1; idle(2); rst = 1'b0; idle(2);
    send(1, K_STP); send(0, 8'h66); send(1, K_END);
    idle(3);
    check("rst_mid_cnt", bytes_q.size(), 2);
    check("rst_mid_b0", byte_at(0), mk(0, 0, 1, 8'h11));
    check("rst_mid_b1", byte_at(1), mk(0, 1, 1, 8'h66));
    check("rst_mid_abort_err", {n_abort[15:0], n_err[15:0]}, 0);

    check("abort_valid_clash", n_clash, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
